pulse_gen640_seq: RTL and testbench
===================================

// Module: pulse_gen640_seq
// PURPOSE
//  Bus-programmable injection sequencer that sits directly upstream of the 640 MHz pulse generator.
//  It issues a train of EXT_START strobes to the pulse generator:
//   - REPEAT strobes, spaced PERIOD BUS_CLK cycles apart.
//   - Each strobe waits until the generator reports done.
//   - A done timeout flags a stuck generator.
//  Sits on the same 8-bit basil-style bus as the generator; everything runs in the BUS_CLK domain.
// PARAMETERS
//  ABUSWIDTH  16  bus address width
//  VERSION    1   value returned at address 0
// PORTS
//  BUS_CLK       in   1          clock; all logic on rising edge
//  RST           in   1          reset, synchronous, active-high
//  BUS_ADD       in   ABUSWIDTH  register address
//  BUS_DATA_IN   in   8          write data
//  BUS_RD        in   1          read strobe; data registered, valid next cycle
//  BUS_WR        in   1          write strobe
//  BUS_DATA_OUT  out  8          read data (registered)
//  PG_DONE       in   1          generator done level; already synchronous to BUS_CLK
//  EXT_START     out  1          start strobe to generator, registered
//  BUSY          out  1          high while a sequence is running
// BEHAVIOUR
//  Register map:
//   0      R: VERSION; W: soft reset (same effect as RST)
//   1      R: {5'b0, ERR, BUSY, DONE}; W: start
//   2      W: stop; R: 0
//   3-6    PERIOD[31:0], LSB first
//   7-8    REPEAT[15:0]
//   9      SWIDTH[7:0]
//   10-11  TIMEOUT[15:0]
//   12-13  FIRED[15:0], read-only
//   other  read 0
//  Reset values (RST or soft reset):
//   - PERIOD=0, REPEAT=1, SWIDTH=1, TIMEOUT=0
//   - FIRED=0, ERR=0, DONE=1, EXT_START=0, BUSY=0
//   - FSM returns to IDLE; BUS_DATA_OUT=0
//  FSM states: IDLE, FIRE, GAP, WAIT.
//  IDLE
//   - Start write in cycle n: FIRE entered, EXT_START=1 from n+1.
//   - On start: FIRED<=0, ERR<=0, DONE<=0, BUSY<=1, rep_cnt<=REPEAT.
//   - Start while not IDLE is ignored.
//  FIRE
//   - EXT_START held high for max(SWIDTH,1) cycles.
//   - FIRED increments by 1 on the first FIRE cycle; saturates at 16'hFFFF.
//   - Then go to GAP.
//  GAP
//   - per_cnt counts BUS_CLK cycles from the first FIRE cycle.
//   - Clear armed on entry to FIRE.
//   - Set armed when PG_DONE==0 is sampled (filters stale done from the previous pulse).
//   - Leave GAP when per_cnt >= PERIOD-1. PERIOD 0 or 1 means back-to-back, gated only by done.
//   - Go to WAIT; the timeout counter restarts on entry to WAIT.
//  WAIT
//   - Accept done when armed && PG_DONE. Then:
//     - REPEAT==0: infinite; re-FIRE immediately.
//     - Else rep_cnt decrements; if rep_cnt becomes 0, go to IDLE with DONE=1, BUSY=0.
//     - Else re-FIRE next cycle.
//   - Timeout: TIMEOUT!=0 and TIMEOUT cycles spent in WAIT without accepted done
//     -> ERR=1, DONE=1, go to IDLE.
//  Stop write: any state -> IDLE next cycle.
//   - EXT_START forced 0.
//   - DONE=1, FIRED kept, ERR unchanged.
//  Simultaneous events, priority: RST/soft reset > stop > timeout > done.
//  Config writes during a run take effect at their next use (PERIOD at the next GAP exit);
//   they are not latched at start.
//  Width rules:
//   - per_cnt 32-bit, saturating.
//   - Timeout counter 16-bit.
//   - rep_cnt 16-bit; never wraps below 0.
//  BUSY = (state != IDLE).
// TESTING
//  1. RST; read addr 0..13
//     -> VERSION=1, status=8'h01, REPEAT=1, SWIDTH=1, others 0.
//  2. PERIOD=100, REPEAT=3, SWIDTH=4; model PG_DONE low 10..40 cycles after each strobe
//     -> 3 strobes of 4 cycles, rising edges 100 cycles apart, FIRED=3, status=8'h01.
//  3. PERIOD=5, REPEAT=2; done returns 50 cycles after strobe
//     -> second strobe gated by done (>=50-cycle spacing), not by PERIOD.
//  4. TIMEOUT=20, PG_DONE stuck 0
//     -> ERR=1 exactly 20 cycles after WAIT entry, status=8'h05, EXT_START stays 0.
//  5. REPEAT=0, then stop after 7 strobes
//     -> IDLE next cycle, FIRED=7, no further strobes.
//     Start during BUSY -> ignored.
//  6. Soft reset (write addr 0) while EXT_START high
//     -> EXT_START=0 next cycle, all config returns to reset values.

Source files
------------

// File: rtl/pulse_gen640_seq.sv
// rtl/pulse_gen640_seq.sv - bus-programmable EXT_START strobe sequencer for the 640 MHz pulse generator
// Issues REPEAT strobes PERIOD cycles apart, each gated by the generator's done level, with a stuck-done timeout.
module pulse_gen640_seq #(
  parameter int         ABUSWIDTH = 16,
  parameter logic [7:0] VERSION   = 8'd1
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 PG_DONE,
  output logic                 EXT_START,
  output logic                 BUSY
);

  typedef enum logic [1:0] {IDLE, FIRE, GAP, WAIT} state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0] period;
  logic [15:0] rep_cfg;
  logic [7:0]  swidth;
  logic [15:0] timeout;

  logic [15:0] fired;
  logic        err;
  logic        done;

  logic [31:0] per_cnt;
  logic [15:0] to_cnt;
  logic [15:0] rep_cnt;
  logic [7:0]  wid_cnt;
  logic        armed;

  logic        wr_soft;
  logic        wr_start;
  logic        wr_stop;
  logic        seq_rst;

  logic        wid_last;
  logic        period_hit;
  logic        timeout_hit;
  logic        done_ok;
  logic        rep_last;

  logic        ev_start;
  logic        ev_accept;
  logic        ev_timeout;
  logic        fire_entry;
  logic        wait_entry;

  logic [7:0]  rd_data;

  assign wr_soft  = BUS_WR && (BUS_ADD == ABUSWIDTH'(0));
  assign wr_start = BUS_WR && (BUS_ADD == ABUSWIDTH'(1));
  assign wr_stop  = BUS_WR && (BUS_ADD == ABUSWIDTH'(2));
  assign seq_rst  = RST || wr_soft;

  // Widened compares: SWIDTH 0 behaves as 1, PERIOD 0 behaves as 1, all without underflow.
  assign wid_last    = ({1'b0, wid_cnt} + 9'd1) >= {1'b0, swidth};
  assign period_hit  = ({1'b0, per_cnt} + 33'd1) >= {1'b0, period};
  assign timeout_hit = (timeout != 16'd0) && (({1'b0, to_cnt} + 17'd1) >= {1'b0, timeout});
  assign done_ok     = armed && PG_DONE;
  assign rep_last    = (rep_cfg != 16'd0) && (rep_cnt <= 16'd1);

  always_ff @(posedge BUS_CLK) begin
    if (seq_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A done already present on the GAP exit cycle is accepted there, so strobes land exactly PERIOD apart.
  always_comb begin
    state_nxt = state;
    if (wr_stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (wr_start) state_nxt = FIRE;
        end
        FIRE: begin
          if (wid_last) state_nxt = GAP;
        end
        GAP: begin
          if (period_hit) begin
            if (done_ok) state_nxt = rep_last ? IDLE : FIRE;
            else         state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (timeout_hit)  state_nxt = IDLE;
          else if (done_ok) state_nxt = rep_last ? IDLE : FIRE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    BUSY       = (state != IDLE);
    ev_start   = (state == IDLE) && wr_start;
    ev_timeout = !wr_stop && (state == WAIT) && timeout_hit;
    ev_accept  = !wr_stop && done_ok &&
                 (((state == GAP) && period_hit) || ((state == WAIT) && !timeout_hit));
    fire_entry = (state != FIRE) && (state_nxt == FIRE);
    wait_entry = (state != WAIT) && (state_nxt == WAIT);
  end

  always_comb begin
    rd_data = 8'h00;
    case (BUS_ADD)
      ABUSWIDTH'(0):  rd_data = VERSION;
      ABUSWIDTH'(1):  rd_data = {5'b0, err, BUSY, done};
      ABUSWIDTH'(3):  rd_data = period[7:0];
      ABUSWIDTH'(4):  rd_data = period[15:8];
      ABUSWIDTH'(5):  rd_data = period[23:16];
      ABUSWIDTH'(6):  rd_data = period[31:24];
      ABUSWIDTH'(7):  rd_data = rep_cfg[7:0];
      ABUSWIDTH'(8):  rd_data = rep_cfg[15:8];
      ABUSWIDTH'(9):  rd_data = swidth;
      ABUSWIDTH'(10): rd_data = timeout[7:0];
      ABUSWIDTH'(11): rd_data = timeout[15:8];
      ABUSWIDTH'(12): rd_data = fired[7:0];
      ABUSWIDTH'(13): rd_data = fired[15:8];
      default:        rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (seq_rst) begin
      period       <= 32'd0;
      rep_cfg      <= 16'd1;
      swidth       <= 8'd1;
      timeout      <= 16'd0;
      fired        <= 16'd0;
      err          <= 1'b0;
      done         <= 1'b1;
      EXT_START    <= 1'b0;
      per_cnt      <= 32'd0;
      to_cnt       <= 16'd0;
      rep_cnt      <= 16'd0;
      wid_cnt      <= 8'd0;
      armed        <= 1'b0;
      BUS_DATA_OUT <= 8'h00;
    end else begin
      EXT_START <= (state_nxt == FIRE);

      if (BUS_RD) BUS_DATA_OUT <= rd_data;

      if (BUS_WR) begin
        case (BUS_ADD)
          ABUSWIDTH'(3):  period[7:0]    <= BUS_DATA_IN;
          ABUSWIDTH'(4):  period[15:8]   <= BUS_DATA_IN;
          ABUSWIDTH'(5):  period[23:16]  <= BUS_DATA_IN;
          ABUSWIDTH'(6):  period[31:24]  <= BUS_DATA_IN;
          ABUSWIDTH'(7):  rep_cfg[7:0]   <= BUS_DATA_IN;
          ABUSWIDTH'(8):  rep_cfg[15:8]  <= BUS_DATA_IN;
          ABUSWIDTH'(9):  swidth         <= BUS_DATA_IN;
          ABUSWIDTH'(10): timeout[7:0]   <= BUS_DATA_IN;
          ABUSWIDTH'(11): timeout[15:8]  <= BUS_DATA_IN;
          default: ;
        endcase
      end

      if (ev_start) begin
        fired   <= 16'd0;
        err     <= 1'b0;
        done    <= 1'b0;
        rep_cnt <= rep_cfg;
      end else if ((state == FIRE) && (wid_cnt == 8'd0) && (fired != 16'hFFFF)) begin
        fired <= fired + 16'd1;
      end

      if (wr_stop) begin
        done <= 1'b1;
      end else if (ev_timeout) begin
        err  <= 1'b1;
        done <= 1'b1;
      end else if (ev_accept && rep_last) begin
        done <= 1'b1;
      end

      if (ev_accept && (rep_cfg != 16'd0) && (rep_cnt != 16'd0)) begin
        rep_cnt <= rep_cnt - 16'd1;
      end

      if (fire_entry) begin
        wid_cnt <= 8'd0;
      end else if ((state == FIRE) && (wid_cnt != 8'hFF)) begin
        wid_cnt <= wid_cnt + 8'd1;
      end

      if (fire_entry) begin
        per_cnt <= 32'd0;
      end else if (((state == FIRE) || (state == GAP)) && (per_cnt != 32'hFFFF_FFFF)) begin
        per_cnt <= per_cnt + 32'd1;
      end

      if (wait_entry) begin
        to_cnt <= 16'd0;
      end else if ((state == WAIT) && (to_cnt != 16'hFFFF)) begin
        to_cnt <= to_cnt + 16'd1;
      end

      // A low done after the strobe proves the generator saw it; a high level before that is stale.
      if (fire_entry) begin
        armed <= 1'b0;
      end else if ((state != IDLE) && !PG_DONE) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_gen640_seq.sv
// tb/tb_pulse_gen640_seq.sv - directed self-checking bench for pulse_gen640_seq
// A small generator model drives PG_DONE; a monitor timestamps strobes and BUSY falls.
`timescale 1ns/1ps
module tb_pulse_gen640_seq;

  logic        BUS_CLK = 1'b0;
  logic        RST;
  logic [15:0] BUS_ADD;
  logic [7:0]  BUS_DATA_IN;
  logic        BUS_RD;
  logic        BUS_WR;
  logic [7:0]  BUS_DATA_OUT;
  logic        PG_DONE = 1'b1;
  logic        EXT_START;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  always #5 BUS_CLK = ~BUS_CLK;

  pulse_gen640_seq #(.ABUSWIDTH(16), .VERSION(8'd1)) dut (
    .BUS_CLK      (BUS_CLK),
    .RST          (RST),
    .BUS_ADD      (BUS_ADD),
    .BUS_DATA_IN  (BUS_DATA_IN),
    .BUS_RD       (BUS_RD),
    .BUS_WR       (BUS_WR),
    .BUS_DATA_OUT (BUS_DATA_OUT),
    .PG_DONE      (PG_DONE),
    .EXT_START    (EXT_START),
    .BUSY         (BUSY)
  );

  int   gen_lo = 10;
  int   gen_hi = 40;
  bit   gen_stuck = 1'b0;
  int   gen_cnt = 10000;
  int   cyc = 0;
  int   rises = 0;
  int   falls = 0;
  int   cur_w = 0;
  int   busy_fall = -1;
  int   rise_t [64];
  int   wid [64];
  logic ext_q = 1'b0;
  logic busy_q = 1'b0;

  // Generator: done drops gen_lo cycles after a strobe edge and returns at gen_hi.
  always @(posedge BUS_CLK) begin
    #1;
    cyc++;
    if (EXT_START && !ext_q) begin
      gen_cnt = 0;
      if (rises < 64) rise_t[rises] = cyc;
      rises++;
    end else if (gen_cnt < 10000) begin
      gen_cnt++;
    end
    if (EXT_START) begin
      cur_w++;
    end else if (ext_q) begin
      if (falls < 64) wid[falls] = cur_w;
      falls++;
      cur_w = 0;
    end
    if (busy_q && !BUSY) busy_fall = cyc;
    ext_q  = EXT_START;
    busy_q = BUSY;
    PG_DONE = gen_stuck ? 1'b0 : !((gen_cnt >= gen_lo) && (gen_cnt < gen_hi));
  end

  task automatic bus_write(input int addr, input logic [7:0] data);
    @(negedge BUS_CLK);
    BUS_ADD     = 16'(addr);
    BUS_DATA_IN = data;
    BUS_WR      = 1'b1;
    @(negedge BUS_CLK);
    BUS_WR      = 1'b0;
  endtask

  task automatic bus_read(input int addr, output logic [7:0] data);
    @(negedge BUS_CLK);
    BUS_ADD = 16'(addr);
    BUS_RD  = 1'b1;
    @(negedge BUS_CLK);
    BUS_RD  = 1'b0;
    data    = BUS_DATA_OUT;
  endtask

  task automatic set_cfg(input logic [31:0] per, input logic [15:0] rep,
                         input logic [7:0] sw, input logic [15:0] tmo);
    bus_write(3, per[7:0]);
    bus_write(4, per[15:8]);
    bus_write(5, per[23:16]);
    bus_write(6, per[31:24]);
    bus_write(7, rep[7:0]);
    bus_write(8, rep[15:8]);
    bus_write(9, sw);
    bus_write(10, tmo[7:0]);
    bus_write(11, tmo[15:8]);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (BUSY && (n < budget)) begin
      @(negedge BUS_CLK);
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s: BUSY still %0b after %0d cycles, required 0", tag, BUSY, budget);
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic [7:0] exp_tab [16];
    exp_tab = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    RST = 1'b1;
    repeat (3) @(negedge BUS_CLK);
    RST = 1'b0;
    checks++;
    if (EXT_START !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: EXT_START=%0b BUSY=%0b required 0 0", EXT_START, BUSY);
    end
    for (int a = 0; a < 16; a++) begin
      bus_read(a, rd);
      checks++;
      if (rd !== exp_tab[a]) begin
        errors++;
        $display("FAIL reset_read addr %0d: got %02h expected %02h", a, rd, exp_tab[a]);
      end
    end
  endtask

  task automatic test_regs();
    logic [7:0] rd;
    logic [7:0] vals [6];
    int         addrs [6];
    vals  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hA5, 8'h5A};
    addrs = '{3, 4, 5, 6, 10, 11};
    for (int i = 0; i < 6; i++) bus_write(addrs[i], vals[i]);
    bus_write(2, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      bus_read(addrs[i], rd);
      checks++;
      if (rd !== vals[i]) begin
        errors++;
        $display("FAIL reg_readback addr %0d: got %02h expected %02h", addrs[i], rd, vals[i]);
      end
    end
    bus_read(2, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL stop_reg_read: got %02h expected 00", rd);
    end
  endtask

  task automatic test_train();
    logic [7:0] rd;
    int rb;
    int fb;
    gen_lo = 10;
    gen_hi = 40;
    set_cfg(32'd100, 16'd3, 8'd4, 16'd0);
    rb = rises;
    fb = falls;
    bus_write(1, 8'h01);
    wait_idle(1000, "train_idle");
    repeat (3) @(negedge BUS_CLK);
    checks++;
    if (rises - rb !== 3) begin
      errors++;
      $display("FAIL train_count: got %0d strobes expected 3", rises - rb);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (rise_t[rb + i] - rise_t[rb + i - 1] !== 100) begin
        errors++;
        $display("FAIL train_spacing %0d: got %0d expected 100", i, rise_t[rb + i] - rise_t[rb + i - 1]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wid[fb + i] !== 4) begin
        errors++;
        $display("FAIL train_width %0d: got %0d expected 4", i, wid[fb + i]);
      end
    end
    bus_read(12, rd);
    checks++;
    if (rd !== 8'h03) begin
      errors++;
      $display("FAIL train_fired_lo: got %02h expected 03", rd);
    end
    bus_read(13, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL train_fired_hi: got %02h expected 00", rd);
    end
    bus_read(1, rd);
    checks++;
    if (rd !== 8'h01) begin
      errors++;
      $display("FAIL train_status: got %02h expected 01", rd);
    end
  endtask

  task automatic test_done_gated();
    int rb;
    gen_lo = 2;
    gen_hi = 50;
    set_cfg(32'd5, 16'd2, 8'd1, 16'd0);
    rb = rises;
    bus_write(1, 8'h01);
    wait_idle(500, "gated_idle");
    repeat (3) @(negedge BUS_CLK);
    checks++;
    if (rises - rb !== 2) begin
      errors++;
      $display("FAIL gated_count: got %0d strobes expected 2", rises - rb);
    end
    checks++;
    if (rise_t[rb + 1] - rise_t[rb] !== 51) begin
      errors++;
      $display("FAIL gated_spacing: got %0d expected 51", rise_t[rb + 1] - rise_t[rb]);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] rd;
    int rb;
    gen_stuck = 1'b1;
    set_cfg(32'd10, 16'd1, 8'd1, 16'd20);
    rb = rises;
    bus_write(1, 8'h01);
    wait_idle(200, "timeout_idle");
    repeat (10) @(negedge BUS_CLK);
    checks++;
    if (busy_fall - rise_t[rb] !== 30) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected 30", busy_fall - rise_t[rb]);
    end
    checks++;
    if (rises - rb !== 1 || EXT_START !== 1'b0) begin
      errors++;
      $display("FAIL timeout_strobes: got %0d strobes EXT_START=%0b expected 1 and 0", rises - rb, EXT_START);
    end
    bus_read(1, rd);
    checks++;
    if (rd !== 8'h05) begin
      errors++;
      $display("FAIL timeout_status: got %02h expected 05", rd);
    end
    gen_stuck = 1'b0;
    bus_write(10, 8'h00);
  endtask

  task automatic test_infinite_stop();
    logic [7:0] rd;
    int rb;
    int n;
    gen_lo = 2;
    gen_hi = 5;
    set_cfg(32'd8, 16'd0, 8'd2, 16'd0);
    rb = rises;
    bus_write(1, 8'h01);
    n = 0;
    while ((rises - rb < 3) && (n < 500)) begin
      @(negedge BUS_CLK);
      n++;
    end
    bus_write(1, 8'h01);
    while ((rises - rb < 7) && (n < 500)) begin
      @(negedge BUS_CLK);
      n++;
    end
    while (EXT_START && (n < 500)) begin
      @(negedge BUS_CLK);
      n++;
    end
    checks++;
    if (rises - rb !== 7) begin
      errors++;
      $display("FAIL inf_reach7: got %0d strobes expected 7", rises - rb);
    end
    bus_write(2, 8'h01);
    checks++;
    if (BUSY !== 1'b0 || EXT_START !== 1'b0) begin
      errors++;
      $display("FAIL stop_next_cycle: BUSY=%0b EXT_START=%0b expected 0 0", BUSY, EXT_START);
    end
    checks++;
    if (rise_t[rb + 6] - rise_t[rb + 5] !== 8) begin
      errors++;
      $display("FAIL inf_spacing: got %0d expected 8", rise_t[rb + 6] - rise_t[rb + 5]);
    end
    repeat (40) @(negedge BUS_CLK);
    checks++;
    if (rises - rb !== 7) begin
      errors++;
      $display("FAIL stop_no_more: got %0d strobes expected 7", rises - rb);
    end
    bus_read(12, rd);
    checks++;
    if (rd !== 8'h07) begin
      errors++;
      $display("FAIL stop_fired: got %02h expected 07", rd);
    end
    bus_read(1, rd);
    checks++;
    if (rd !== 8'h01) begin
      errors++;
      $display("FAIL stop_status: got %02h expected 01", rd);
    end
  endtask

  task automatic test_soft_reset();
    logic [7:0] rd;
    int n;
    int   addrs [7];
    logic [7:0] exp_v [7];
    addrs = '{1, 3, 4, 7, 8, 9, 10};
    exp_v = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
    set_cfg(32'd1000, 16'd5, 8'd50, 16'd7);
    bus_write(1, 8'h01);
    n = 0;
    while (!EXT_START && (n < 20)) begin
      @(negedge BUS_CLK);
      n++;
    end
    checks++;
    if (EXT_START !== 1'b1) begin
      errors++;
      $display("FAIL soft_pre: EXT_START=%0b expected 1", EXT_START);
    end
    bus_write(0, 8'h00);
    checks++;
    if (EXT_START !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL soft_outputs: EXT_START=%0b BUSY=%0b expected 0 0", EXT_START, BUSY);
    end
    for (int i = 0; i < 7; i++) begin
      bus_read(addrs[i], rd);
      checks++;
      if (rd !== exp_v[i]) begin
        errors++;
        $display("FAIL soft_read addr %0d: got %02h expected %02h", addrs[i], rd, exp_v[i]);
      end
    end
  endtask

  initial begin
    RST         = 1'b1;
    BUS_ADD     = 16'd0;
    BUS_DATA_IN = 8'd0;
    BUS_RD      = 1'b0;
    BUS_WR      = 1'b0;
    test_reset();
    test_regs();
    test_train();
    test_done_gated();
    test_timeout();
    test_infinite_stop();
    test_soft_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
